// File: rtl/mask_track_pkg.sv
// ============================================================================
// Module      : mask_track_pkg
// Description : Shared widths, defaults, FSM states and accumulator record
//               for the mask_track object tracker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mask_track_pkg;

    localparam int COUNT_W = 19;
    localparam int SUM_W   = 28;
    localparam int COORD_W = 13;

    localparam logic [COORD_W-1:0] DEF_ROW_MAX    = 13'd477;
    localparam logic [COORD_W-1:0] DEF_COL_MAX    = 13'd617;
    localparam logic [COUNT_W-1:0] DEF_MIN_PIXELS = 19'd64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCUM  = 3'd1,
        ST_DIV_C  = 3'd2,
        ST_DIV_R  = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    typedef struct packed {
        logic [COUNT_W-1:0] count;
        logic [SUM_W-1:0]   sum_row;
        logic [SUM_W-1:0]   sum_col;
        logic [COORD_W-1:0] rmin;
        logic [COORD_W-1:0] rmax;
        logic [COORD_W-1:0] cmin;
        logic [COORD_W-1:0] cmax;
    } acc_t;

    // Frame-start value: mins saturated high so the first pixel always wins.
    function automatic acc_t acc_init();
        acc_t a;
        a.count   = '0;
        a.sum_row = '0;
        a.sum_col = '0;
        a.rmin    = '1;
        a.rmax    = '0;
        a.cmin    = '1;
        a.cmax    = '0;
        return a;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mask_track_seq_divider.sv
// ============================================================================
// Module      : seq_divider
// Description : Restoring unsigned divider, one quotient bit per cycle; the
//               start cycle performs the first step, done pulses after the last.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
    import mask_track_pkg::*;
#(
    parameter int DIVIDEND_W = SUM_W,
    parameter int DIVISOR_W  = COUNT_W,
    parameter int QUOTIENT_W = COORD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic                  o_done,
    output logic [QUOTIENT_W-1:0] o_quotient
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVIDEND_W-1:0] r_quo;
    logic [DIVISOR_W-1:0]  r_div;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic                  r_done;

    logic [DIVISOR_W-1:0]  w_rem_src;
    logic [DIVIDEND_W-1:0] w_quo_src;
    logic [DIVISOR_W-1:0]  w_div_src;
    logic [DIVISOR_W:0]    w_shift;
    logic                  w_ge;
    logic [DIVISOR_W-1:0]  w_rem_nxt;
    logic [DIVIDEND_W-1:0] w_quo_nxt;

    always_comb begin
        w_rem_src = i_start ? '0         : r_rem;
        w_quo_src = i_start ? i_dividend : r_quo;
        w_div_src = i_start ? i_divisor  : r_div;
        w_shift   = {w_rem_src, w_quo_src[DIVIDEND_W-1]};
        w_ge      = (w_shift >= {1'b0, w_div_src});
        // True remainder is below the divisor, so modular subtraction is exact.
        w_rem_nxt = w_ge ? (w_shift[DIVISOR_W-1:0] - w_div_src) : w_shift[DIVISOR_W-1:0];
        w_quo_nxt = {w_quo_src[DIVIDEND_W-2:0], w_ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= w_rem_nxt;
                r_quo  <= w_quo_nxt;
                r_div  <= i_divisor;
                r_cnt  <= CNT_W'(DIVIDEND_W - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done     = r_done;
    assign o_quotient = r_quo[QUOTIENT_W-1:0];

endmodule

`default_nettype wire

// File: rtl/mask_track.sv
// ============================================================================
// Module      : mask_track
// Description : Per-frame bounding box, pixel count and centroid of flagged
//               pixels. Optional MASK_TRACK_DENOISE_EN rejects runs under 3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mask_track
    import mask_track_pkg::*;
#(
    parameter logic [COORD_W-1:0] ROW_MAX    = DEF_ROW_MAX,
    parameter logic [COORD_W-1:0] COL_MAX    = DEF_COL_MAX,
    parameter logic [COUNT_W-1:0] MIN_PIXELS = DEF_MIN_PIXELS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    input  logic               in_color,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               found,
    output logic [COUNT_W-1:0] pix_count,
    output logic [COORD_W-1:0] box_rmin,
    output logic [COORD_W-1:0] box_rmax,
    output logic [COORD_W-1:0] box_cmin,
    output logic [COORD_W-1:0] box_cmax,
    output logic [COORD_W-1:0] cent_row,
    output logic [COORD_W-1:0] cent_col,
    output logic               frame_drop
);

    logic w_start_frame;
    logic w_end_frame;
    logic w_in_win;
    logic w_flag;
    logic w_hit;

    assign w_start_frame = pix_valid && (row == '0) && (col == '0);
    assign w_end_frame   = pix_valid && (row == ROW_MAX) && (col == COL_MAX);
    assign w_in_win      = (row <= ROW_MAX) && (col <= COL_MAX);

`ifdef MASK_TRACK_DENOISE_EN
    logic [1:0] r_hist;
    logic [1:0] w_hist_src;

    // r_hist[0] is the previous sample's flag, r_hist[1] the one before.
    always_comb begin
        w_hist_src = (col == '0) ? 2'b00 : r_hist;
        w_flag     = in_color && (&w_hist_src);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= 2'b00;
        end else if (pix_valid) begin
            r_hist <= {w_hist_src[0], in_color};
        end
    end
`else
    assign w_flag = in_color;
`endif

    assign w_hit = pix_valid && w_in_win && w_flag;

    acc_t r_acc;
    acc_t w_acc_base;
    acc_t w_acc_nxt;
    acc_t r_snap;

    always_comb begin
        w_acc_base = w_start_frame ? acc_init() : r_acc;
        w_acc_nxt  = w_acc_base;
        if (w_hit) begin
            w_acc_nxt.count   = w_acc_base.count + COUNT_W'(1);
            w_acc_nxt.sum_row = w_acc_base.sum_row + SUM_W'(row);
            w_acc_nxt.sum_col = w_acc_base.sum_col + SUM_W'(col);
            if (row < w_acc_base.rmin) w_acc_nxt.rmin = row;
            if (row > w_acc_base.rmax) w_acc_nxt.rmax = row;
            if (col < w_acc_base.cmin) w_acc_nxt.cmin = col;
            if (col > w_acc_base.cmax) w_acc_nxt.cmax = col;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_nxt;
        end
    end

    state_t r_state;
    state_t w_state_nxt;
    logic   r_started;
    logic   w_div_start;
    logic   w_load_snap;
    logic   w_cap_col;
    logic   w_cap_out;
    logic   w_drop;
    logic   w_div_done;
    logic [COORD_W-1:0] w_quotient;
    logic [SUM_W-1:0]   w_dividend;

    always_comb begin
        w_state_nxt = r_state;
        w_div_start = 1'b0;
        w_load_snap = 1'b0;
        w_cap_col   = 1'b0;
        w_cap_out   = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_frame) w_state_nxt = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (w_end_frame) begin
                    w_load_snap = 1'b1;
                    w_state_nxt = ST_DIV_C;
                end
            end
            ST_DIV_C: begin
                w_div_start = !r_started;
                w_drop      = w_end_frame;
                if (w_div_done) begin
                    w_cap_col   = 1'b1;
                    w_state_nxt = ST_DIV_R;
                end
            end
            ST_DIV_R: begin
                w_div_start = !r_started;
                w_drop      = w_end_frame;
                if (w_div_done) begin
                    w_cap_out   = 1'b1;
                    w_state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: begin
                w_drop = w_end_frame;
                if (result_ready) w_state_nxt = ST_ACCUM;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // r_started marks that the divide for the current state has been launched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_started <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_started <= 1'b0;
            end else if (w_div_start) begin
                r_started <= 1'b1;
            end
        end
    end

    assign w_dividend = (r_state == ST_DIV_C) ? r_snap.sum_col : r_snap.sum_row;

    seq_divider #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (COUNT_W),
        .QUOTIENT_W (COORD_W)
    ) u_div (
        .clk        (clk),
        .rst        (reset),
        .i_start    (w_div_start),
        .i_dividend (w_dividend),
        .i_divisor  (r_snap.count),
        .o_done     (w_div_done),
        .o_quotient (w_quotient)
    );

    logic               r_found;
    logic [COUNT_W-1:0] r_pix_count;
    logic [COORD_W-1:0] r_rmin;
    logic [COORD_W-1:0] r_rmax;
    logic [COORD_W-1:0] r_cmin;
    logic [COORD_W-1:0] r_cmax;
    logic [COORD_W-1:0] r_qcol;
    logic [COORD_W-1:0] r_cent_row;
    logic [COORD_W-1:0] r_cent_col;
    logic               r_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap      <= '0;
            r_qcol      <= '0;
            r_found     <= 1'b0;
            r_pix_count <= '0;
            r_rmin      <= '0;
            r_rmax      <= '0;
            r_cmin      <= '0;
            r_cmax      <= '0;
            r_cent_row  <= '0;
            r_cent_col  <= '0;
            r_drop      <= 1'b0;
        end else begin
            r_drop <= w_drop;
            if (w_load_snap) r_snap <= w_acc_nxt;
            if (w_cap_col)   r_qcol <= w_quotient;
            if (w_cap_out) begin
                r_pix_count <= r_snap.count;
                // An empty frame has no box; its divider result is meaningless.
                if (r_snap.count == '0) begin
                    r_found    <= 1'b0;
                    r_rmin     <= '0;
                    r_rmax     <= '0;
                    r_cmin     <= '0;
                    r_cmax     <= '0;
                    r_cent_row <= '0;
                    r_cent_col <= '0;
                end else begin
                    r_found    <= (r_snap.count >= MIN_PIXELS);
                    r_rmin     <= r_snap.rmin;
                    r_rmax     <= r_snap.rmax;
                    r_cmin     <= r_snap.cmin;
                    r_cmax     <= r_snap.cmax;
                    r_cent_row <= w_quotient;
                    r_cent_col <= r_qcol;
                end
            end
        end
    end

    assign result_valid = (r_state == ST_REPORT);
    assign found        = r_found;
    assign pix_count    = r_pix_count;
    assign box_rmin     = r_rmin;
    assign box_rmax     = r_rmax;
    assign box_cmin     = r_cmin;
    assign box_cmax     = r_cmax;
    assign cent_row     = r_cent_row;
    assign cent_col     = r_cent_col;
    assign frame_drop   = r_drop;

endmodule

`default_nettype wire

// File: doc/mask_track.md
# mask_track

Per-frame object tracker fed by the per-pixel color-detect stream (pixel RGB pass-through plus a 1-bit color flag, 478×618 active window). Accumulates the flagged pixels of each frame and reports the bounding box, pixel count and centroid once per frame over a valid/ready handshake. Sits downstream of the HSV classifier and upstream of the overlay and control logic.

## Interface
- ROW_MAX, 13'd477: last active row (inclusive).
- COL_MAX, 13'd617: last active column (inclusive).
- MIN_PIXELS, 19'd64: minimum flagged count for `found`.
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- pix_valid  in  1  pixel sample present this cycle.
- row  in  13  pixel row.
- col  in  13  pixel column.
- in_color  in  1  pixel classified as target color.
- result_valid  out  1  result fields valid; held until accepted.
- result_ready  in  1  consumer accepts the result.
- found  out  1  count ≥ MIN_PIXELS.
- pix_count  out  19  flagged pixels in the frame.
- box_rmin, box_rmax, box_cmin, box_cmax  out  13 each  bounding box.
- cent_row, cent_col  out  13 each  centroid, truncated quotient.
- frame_drop  out  1  one-cycle pulse when a completed frame is discarded.

## Operation
- Pixels are counted only when pix_valid=1, in_color=1, row≤ROW_MAX and col≤COL_MAX.
- Frame start: an accepted sample at (0,0) reloads the accumulators. Count and sums are cleared, mins are set to all-ones and maxes to zero, and then the (0,0) pixel itself is applied.
- Accumulators are count (19b), sum_row (28b) and sum_col (28b), together with the min/max row and column.
- Frame end: an accepted sample at (ROW_MAX,COL_MAX). The totals, including that pixel, are snapshotted into a result buffer. Accumulation for the next frame proceeds independently.
- FSM states:
  - IDLE: after reset; waits for the first frame start. A frame end seen before any frame start is ignored.
  - ACCUM: waits for frame end, then goes to DIV_C.
  - DIV_C: computes sum_col/count over 28 cycles, then goes to DIV_R.
  - DIV_R: computes sum_row/count over 28 cycles, then goes to REPORT.
  - REPORT: result_valid=1. On result_ready, goes back to ACCUM.
- count==0:
  - The divider is bypassed and both centroids are 0.
  - All box fields output 0 and found=0.
  - The same fixed latency still applies.
- A frame end that occurs in DIV_C, DIV_R or REPORT does not touch the result buffer or the FSM, and frame_drop pulses for one cycle.
- Quotients are truncated. Only the low 13 bits of each quotient are output; they always fit by construction.

## Timing
- Reset values: all outputs 0, FSM in IDLE, accumulators cleared.
- Accumulator update: the cycle after sample acceptance.
- Latency: result_valid rises exactly 58 cycles (2×28+2) after the edge that accepts the frame-end sample.
- Output stability: result fields are stable from the result_valid rise until the accepting edge (result_valid && result_ready). result_valid drops the cycle after that edge.
- result_ready is ignored while result_valid=0.
- reset mid-operation: the partial frame and any pending result are discarded. frame_drop does not pulse.
- Worst-case drain is 58 cycles plus the consumer stall; horizontal blanking covers the divide.

## Configuration
- MASK_TRACK_DENOISE_EN defined: a 2-deep shift register holds the flags of the previous two accepted samples in the same row, and is cleared when col==0. A pixel counts only when it and both previous samples are flagged, so isolated runs of 1–2 pixels are rejected. Coordinates attributed to a counted pixel are the current (row,col).
- Undefined: raw in_color qualifies directly.

## Structure
- Shared package `mask_track_pkg`: COUNT_W=19, SUM_W=28, COORD_W=13, the FSM state enum, and the default ROW_MAX/COL_MAX.
- Sub-module `seq_divider`: restoring divider, 28b dividend by 19b divisor, 1 bit per cycle, with start/done. It is instantiated once and reused for both quotients.

## Test plan
- Single flagged pixel at (100,200) in an otherwise empty frame, MIN_PIXELS=1:
  - Expected: count=1, box 100..100/200..200, centroid (100,200), found=1.
  - result_valid rises 58 cycles after the frame-end sample.
- Flagged 10×20 rectangle with rows 50–59 and cols 300–319:
  - Expected: count=200, box 50/59/300/319, cent_row=54 (truncated from 54.5), cent_col=309.
- Empty frame:
  - Expected: count=0, found=0, all box and centroid fields 0, fixed 58-cycle latency.
- result_ready held low across the next frame end:
  - Expected: frame_drop pulses once and the first result stays unchanged.
  - After ready, the third frame reports normally.
- reset asserted during DIV_C:
  - Expected: all outputs 0 the next cycle and no result for that frame.
  - The following full frame reports correctly.
- With MASK_TRACK_DENOISE_EN, row 10 flags cols 5–6 (run of 2) and cols 20–24 (run of 5):
  - Expected: count=3, box_cmin=22, box_cmax=24.
